// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: processor-side request/response channel of the SRAM controller.
interface sram_ctrl_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int WAIT_WIDTH = 4
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [WAIT_WIDTH-1:0] wait_cfg;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   modport master (
      output req_valid, req_write, req_addr, req_wdata, wait_cfg,
      input  req_ready, resp_valid, resp_rdata
   );
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, wait_cfg,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: one-at-a-time asynchronous SRAM access sequencer with programmable
// wait states and read-to-write bus turnaround; all pin outputs are registered.
module sram_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int WAIT_WIDTH = 4,
   parameter int TURNAROUND = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   sram_ctrl_if.slave            bus,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic [ADDR_WIDTH-1:0] sram_adr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_oe,
   input  logic [DATA_WIDTH-1:0] data_in
);
   typedef enum logic [2:0] {IDLE, TURN, SETUP, ACCESS, HOLD} state_t;
   state_t                state, state_nxt;
   logic                  wr, wr_nxt, last_read, accept, done, act_nxt;
   logic [WAIT_WIDTH-1:0] cnt, cnt_nxt;
   logic [2:0]            turn_cnt, turn_nxt;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   assign bus.req_ready  = reset && state == IDLE;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_rdata = resp_rdata;
   assign accept         = bus.req_valid && bus.req_ready;
   always_comb begin
      state_nxt = state;
      wr_nxt    = wr;
      cnt_nxt   = cnt;
      turn_nxt  = turn_cnt;
      done      = 1'b0;
      case (state)
         IDLE: if (accept) begin
            wr_nxt    = bus.req_write;
            cnt_nxt   = (bus.wait_cfg == '0) ? WAIT_WIDTH'(1) : bus.wait_cfg;
            turn_nxt  = 3'(TURNAROUND);
            state_nxt = (bus.req_write && last_read && TURNAROUND > 0) ? TURN : SETUP;
         end
         TURN: begin
            turn_nxt  = turn_cnt - 3'd1;
            state_nxt = (turn_cnt == 3'd1) ? SETUP : TURN;
         end
         SETUP: state_nxt = ACCESS;
         ACCESS: if (cnt == WAIT_WIDTH'(1)) begin
            state_nxt = wr ? HOLD : IDLE;
            done      = !wr;
         end else begin
            cnt_nxt = cnt - WAIT_WIDTH'(1);
         end
         HOLD: begin
            state_nxt = IDLE;
            done      = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end
   // Pins are decoded from the next state so they line up with the state register.
   assign act_nxt = state_nxt inside {SETUP, ACCESS, HOLD};
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         wr         <= 1'b0;
         cnt        <= '0;
         turn_cnt   <= '0;
         last_read  <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         data_oe    <= 1'b0;
         sram_adr   <= '0;
         data_out   <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state      <= state_nxt;
         wr         <= wr_nxt;
         cnt        <= cnt_nxt;
         turn_cnt   <= turn_nxt;
         sram_ce_n  <= !act_nxt;
         sram_oe_n  <= !(act_nxt && !wr_nxt);
         sram_we_n  <= !(state_nxt == ACCESS && wr_nxt);
         data_oe    <= act_nxt && wr_nxt;
         resp_valid <= done;
         if (done) last_read <= !wr;
         if (accept) sram_adr <= bus.req_addr;
         if (accept && bus.req_write) data_out <= bus.req_wdata;
         if (state == ACCESS && cnt == WAIT_WIDTH'(1) && !wr) resp_rdata <= data_in;
      end
   end
   a_no_overlap: assert property (@(posedge clk) disable iff (!reset) sram_oe_n || sram_we_n);
   a_no_contention: assert property (@(posedge clk) disable iff (!reset) !(data_oe && !sram_oe_n));
endmodule
